// File: rtl/bp_zynq_mem_axi_bridge_if.sv
// BedRock memory fwd/rev channels plus the AXI4 master port of the Zynq HP bridge.
interface bp_zynq_mem_axi_bridge_if #(
  parameter int unsigned paddr_width_p    = 34,
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned payload_width_p  = 16,
  parameter int unsigned axi_addr_width_p = 32
);
  localparam int unsigned strb_width_lp = data_width_p / 8;

  // BedRock memory-forward
  logic                        mem_fwd_v_i;
  logic                        mem_fwd_ready_and_o;
  logic                        mem_fwd_last_i;
  logic [3:0]                  mem_fwd_msg_type_i;
  logic [paddr_width_p-1:0]    mem_fwd_addr_i;
  logic [2:0]                  mem_fwd_size_i;
  logic [payload_width_p-1:0]  mem_fwd_payload_i;
  logic [data_width_p-1:0]     mem_fwd_data_i;

  // BedRock memory-reverse
  logic                        mem_rev_v_o;
  logic                        mem_rev_ready_and_i;
  logic                        mem_rev_last_o;
  logic [3:0]                  mem_rev_msg_type_o;
  logic [paddr_width_p-1:0]    mem_rev_addr_o;
  logic [2:0]                  mem_rev_size_o;
  logic [payload_width_p-1:0]  mem_rev_payload_o;
  logic [data_width_p-1:0]     mem_rev_data_o;

  // AXI4 write address / data / response
  logic [axi_addr_width_p-1:0] m_axi_awaddr_o;
  logic [7:0]                  m_axi_awlen_o;
  logic [2:0]                  m_axi_awsize_o;
  logic [1:0]                  m_axi_awburst_o;
  logic                        m_axi_awvalid_o;
  logic                        m_axi_awready_i;
  logic [data_width_p-1:0]     m_axi_wdata_o;
  logic [strb_width_lp-1:0]    m_axi_wstrb_o;
  logic                        m_axi_wlast_o;
  logic                        m_axi_wvalid_o;
  logic                        m_axi_wready_i;
  logic [1:0]                  m_axi_bresp_i;
  logic                        m_axi_bvalid_i;
  logic                        m_axi_bready_o;

  // AXI4 read address / data
  logic [axi_addr_width_p-1:0] m_axi_araddr_o;
  logic [7:0]                  m_axi_arlen_o;
  logic [2:0]                  m_axi_arsize_o;
  logic [1:0]                  m_axi_arburst_o;
  logic                        m_axi_arvalid_o;
  logic                        m_axi_arready_i;
  logic [data_width_p-1:0]     m_axi_rdata_i;
  logic [1:0]                  m_axi_rresp_i;
  logic                        m_axi_rlast_i;
  logic                        m_axi_rvalid_i;
  logic                        m_axi_rready_o;

  // Bridge side
  modport master (
    input  mem_fwd_v_i, mem_fwd_last_i, mem_fwd_msg_type_i, mem_fwd_addr_i,
           mem_fwd_size_i, mem_fwd_payload_i, mem_fwd_data_i,
    output mem_fwd_ready_and_o,
    output mem_rev_v_o, mem_rev_last_o, mem_rev_msg_type_o, mem_rev_addr_o,
           mem_rev_size_o, mem_rev_payload_o, mem_rev_data_o,
    input  mem_rev_ready_and_i,
    output m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o, m_axi_awvalid_o,
    input  m_axi_awready_i,
    output m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o, m_axi_wvalid_o,
    input  m_axi_wready_i,
    input  m_axi_bresp_i, m_axi_bvalid_i,
    output m_axi_bready_o,
    output m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o, m_axi_arvalid_o,
    input  m_axi_arready_i,
    input  m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i, m_axi_rvalid_i,
    output m_axi_rready_o
  );

  // Processor / memory-system side
  modport slave (
    output mem_fwd_v_i, mem_fwd_last_i, mem_fwd_msg_type_i, mem_fwd_addr_i,
           mem_fwd_size_i, mem_fwd_payload_i, mem_fwd_data_i,
    input  mem_fwd_ready_and_o,
    input  mem_rev_v_o, mem_rev_last_o, mem_rev_msg_type_o, mem_rev_addr_o,
           mem_rev_size_o, mem_rev_payload_o, mem_rev_data_o,
    output mem_rev_ready_and_i,
    input  m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o, m_axi_awvalid_o,
    output m_axi_awready_i,
    input  m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o, m_axi_wvalid_o,
    output m_axi_wready_i,
    output m_axi_bresp_i, m_axi_bvalid_i,
    input  m_axi_bready_o,
    input  m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o, m_axi_arvalid_o,
    output m_axi_arready_i,
    output m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i, m_axi_rvalid_i,
    input  m_axi_rready_o
  );
endinterface

// File: rtl/bp_zynq_mem_axi_bridge.sv
// BedRock memory-forward/reverse to AXI4 bridge toward the Zynq PS HP DRAM port.
// Single outstanding transaction; R and W data paths are combinational pass-throughs.
module bp_zynq_mem_axi_bridge #(
  parameter int unsigned             paddr_width_p    = 34,
  parameter int unsigned             data_width_p     = 64,
  parameter int unsigned             payload_width_p  = 16,
  parameter int unsigned             axi_addr_width_p = 32,
  parameter logic [paddr_width_p-1:0] dram_base_p     = paddr_width_p'(34'h0_8000_0000)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_zynq_mem_axi_bridge_if.master bus,
  output logic                     error_o
);

  localparam int unsigned strb_width_lp = data_width_p / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;
  localparam logic [2:0] S_ACK     = 3'd6;
  localparam logic [2:0] S_DRAIN   = 3'd7;

  localparam logic [3:0] MSG_RD    = 4'd0;
  localparam logic [3:0] MSG_WR    = 4'd1;
  localparam logic [3:0] MSG_UC_RD = 4'd2;
  localparam logic [3:0] MSG_UC_WR = 4'd3;

  logic [2:0]                  r_state;
  logic [3:0]                  r_msg_type;
  logic [paddr_width_p-1:0]    r_addr;
  logic [2:0]                  r_size;
  logic [payload_width_p-1:0]  r_payload;
  logic                        r_error;

  logic [2:0]                  w_state_n;
  logic                        w_error_set;
  logic [axi_addr_width_p-1:0] w_addr_mask;
  logic [axi_addr_width_p-1:0] w_axaddr;
  logic [7:0]                  w_axlen;
  logic [2:0]                  w_axsize;
  logic [strb_width_lp-1:0]    w_wstrb;

  // Burst geometry from the latched header; full-line sizes are aligned, sub-word sizes kept exact
  assign w_addr_mask = (r_size >= 3'd3)
                     ? ~((axi_addr_width_p'(1) << r_size) - axi_addr_width_p'(1))
                     : '1;
  assign w_axaddr    = axi_addr_width_p'(r_addr - dram_base_p) & w_addr_mask;
  assign w_axlen     = (r_size > 3'd3) ? ((8'd1 << (r_size - 3'd3)) - 8'd1) : 8'd0;
  assign w_axsize    = (r_size > 3'd3) ? 3'd3 : r_size;

  // Byte strobes: whole beat for 8B and up, otherwise a lane mask shifted to the byte offset
  always_comb begin
    w_wstrb = '1;
    case (r_size)
      3'd0:    w_wstrb = strb_width_lp'(8'h01) << r_addr[2:0];
      3'd1:    w_wstrb = strb_width_lp'(8'h03) << r_addr[2:0];
      3'd2:    w_wstrb = strb_width_lp'(8'h0F) << r_addr[2:0];
      default: w_wstrb = '1;
    endcase
  end

  assign bus.m_axi_araddr_o  = w_axaddr;
  assign bus.m_axi_arlen_o   = w_axlen;
  assign bus.m_axi_arsize_o  = w_axsize;
  assign bus.m_axi_arburst_o = 2'b01;
  assign bus.m_axi_awaddr_o  = w_axaddr;
  assign bus.m_axi_awlen_o   = w_axlen;
  assign bus.m_axi_awsize_o  = w_axsize;
  assign bus.m_axi_awburst_o = 2'b01;
  assign bus.m_axi_wdata_o   = bus.mem_fwd_data_i;
  assign bus.m_axi_wstrb_o   = w_wstrb;

  assign bus.mem_rev_msg_type_o = r_msg_type;
  assign bus.mem_rev_addr_o     = r_addr;
  assign bus.mem_rev_size_o     = r_size;
  assign bus.mem_rev_payload_o  = r_payload;
  assign error_o                = r_error;

  // Next-state and handshake steering per state
  always_comb begin
    w_state_n               = r_state;
    w_error_set             = 1'b0;
    bus.mem_fwd_ready_and_o = 1'b0;
    bus.mem_rev_v_o         = 1'b0;
    bus.mem_rev_last_o      = 1'b0;
    bus.mem_rev_data_o      = '0;
    bus.m_axi_arvalid_o     = 1'b0;
    bus.m_axi_awvalid_o     = 1'b0;
    bus.m_axi_wvalid_o      = 1'b0;
    bus.m_axi_wlast_o       = 1'b0;
    bus.m_axi_bready_o      = 1'b0;
    bus.m_axi_rready_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_fwd_v_i) begin
          case (bus.mem_fwd_msg_type_i)
            MSG_RD, MSG_UC_RD: w_state_n = S_RD_ADDR;
            MSG_WR, MSG_UC_WR: w_state_n = S_WR_ADDR;
            default: begin
              w_state_n   = S_DRAIN;
              w_error_set = 1'b1;
            end
          endcase
        end
      end
      S_RD_ADDR: begin
        bus.m_axi_arvalid_o     = 1'b1;
        bus.mem_fwd_ready_and_o = bus.m_axi_arready_i;
        if (bus.m_axi_arready_i) w_state_n = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus.mem_rev_v_o    = bus.m_axi_rvalid_i;
        bus.mem_rev_last_o = bus.m_axi_rlast_i;
        bus.mem_rev_data_o = bus.m_axi_rdata_i;
        bus.m_axi_rready_o = bus.mem_rev_ready_and_i;
        if (bus.m_axi_rvalid_i && bus.mem_rev_ready_and_i) begin
          w_error_set = (bus.m_axi_rresp_i != 2'b00);
          if (bus.m_axi_rlast_i) w_state_n = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        bus.m_axi_awvalid_o = 1'b1;
        if (bus.m_axi_awready_i) w_state_n = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus.m_axi_wvalid_o      = bus.mem_fwd_v_i;
        bus.m_axi_wlast_o       = bus.mem_fwd_last_i;
        bus.mem_fwd_ready_and_o = bus.m_axi_wready_i;
        if (bus.mem_fwd_v_i && bus.m_axi_wready_i && bus.mem_fwd_last_i) w_state_n = S_WR_RESP;
      end
      S_WR_RESP: begin
        bus.m_axi_bready_o = 1'b1;
        if (bus.m_axi_bvalid_i) begin
          w_error_set = (bus.m_axi_bresp_i != 2'b00);
          w_state_n   = S_ACK;
        end
      end
      S_ACK: begin
        bus.mem_rev_v_o    = 1'b1;
        bus.mem_rev_last_o = 1'b1;
        if (bus.mem_rev_ready_and_i) w_state_n = S_IDLE;
      end
      S_DRAIN: begin
        bus.mem_fwd_ready_and_o = 1'b1;
        if (bus.mem_fwd_v_i && bus.mem_fwd_last_i) w_state_n = S_ACK;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, header latch on first IDLE valid, and sticky error
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_msg_type <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_payload  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_error <= r_error | w_error_set;
      if ((r_state == S_IDLE) && bus.mem_fwd_v_i) begin
        r_msg_type <= bus.mem_fwd_msg_type_i;
        r_addr     <= bus.mem_fwd_addr_i;
        r_size     <= bus.mem_fwd_size_i;
        r_payload  <= bus.mem_fwd_payload_i;
      end
    end
  end

endmodule

// File: tb/tb_bp_zynq_mem_axi_bridge.sv
// Randomized bench: drives BedRock requests, plays the AXI slave over a word memory,
// and checks every beat against addresses/strobes/data derived from the bridge's rules.
module tb_bp_zynq_mem_axi_bridge;
  localparam logic [33:0] BASE = 34'h0_8000_0000;

  logic clk;
  logic rst;
  logic error;
  int   n_checks;
  int   n_errors;
  logic exp_err;
  logic [63:0] mem [int unsigned];

  bp_zynq_mem_axi_bridge_if bus ();

  bp_zynq_mem_axi_bridge dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus),
    .error_o (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules
  function automatic int unsigned m_axaddr(input logic [33:0] a, input int s);
    logic [33:0] d;
    int unsigned o;
    d = a - BASE;
    o = d[31:0];
    if (s >= 3) o = (o / (32'd1 << s)) * (32'd1 << s);
    return o;
  endfunction

  function automatic int m_beats(input int s);
    int b;
    b = (1 << s) / 8;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic logic [7:0] m_strb(input logic [33:0] a, input int s);
    int bytes;
    if (s >= 3) return 8'hFF;
    bytes = 1 << s;
    return 8'(((1 << bytes) - 1) << a[2:0]);
  endfunction

  function automatic logic [63:0] mem_rd(input int unsigned w);
    if (mem.exists(w)) return mem[w];
    return {32'(w) ^ 32'hA5A5_5A5A, 32'(w)};
  endfunction

  task automatic clear_inputs();
    bus.mem_fwd_v_i         = 1'b0;
    bus.mem_fwd_last_i      = 1'b0;
    bus.mem_fwd_msg_type_i  = '0;
    bus.mem_fwd_addr_i      = '0;
    bus.mem_fwd_size_i      = '0;
    bus.mem_fwd_payload_i   = '0;
    bus.mem_fwd_data_i      = '0;
    bus.mem_rev_ready_and_i = 1'b0;
    bus.m_axi_awready_i     = 1'b0;
    bus.m_axi_wready_i      = 1'b0;
    bus.m_axi_bresp_i       = '0;
    bus.m_axi_bvalid_i      = 1'b0;
    bus.m_axi_arready_i     = 1'b0;
    bus.m_axi_rdata_i       = '0;
    bus.m_axi_rresp_i       = '0;
    bus.m_axi_rlast_i       = 1'b0;
    bus.m_axi_rvalid_i      = 1'b0;
  endtask

  task automatic check_all_idle(input string tag);
    check_eq({tag, "_arvalid"}, bus.m_axi_arvalid_o, 0);
    check_eq({tag, "_awvalid"}, bus.m_axi_awvalid_o, 0);
    check_eq({tag, "_wvalid"},  bus.m_axi_wvalid_o, 0);
    check_eq({tag, "_bready"},  bus.m_axi_bready_o, 0);
    check_eq({tag, "_rready"},  bus.m_axi_rready_o, 0);
    check_eq({tag, "_rev_v"},   bus.mem_rev_v_o, 0);
    check_eq({tag, "_fwd_rdy"}, bus.mem_fwd_ready_and_o, 0);
    check_eq({tag, "_error"},   error, 0);
    check_eq({tag, "_hdr_addr"}, bus.mem_rev_addr_o, 0);
    check_eq({tag, "_hdr_pay"},  bus.mem_rev_payload_o, 0);
  endtask

  task automatic check_hdr(input logic [3:0] t, input logic [33:0] a, input logic [2:0] s,
                           input logic [15:0] pay);
    check_eq("hdr_type", bus.mem_rev_msg_type_o, t);
    check_eq("hdr_addr", bus.mem_rev_addr_o, a);
    check_eq("hdr_size", bus.mem_rev_size_o, s);
    check_eq("hdr_payload", bus.mem_rev_payload_o, pay);
  endtask

  task automatic do_read(input logic [3:0] t, input logic [33:0] a, input logic [2:0] s,
                         input int err_beat, input int abort_at);
    int unsigned ea;
    int          nb;
    int          k;
    logic        hs;
    logic [15:0] pay;
    logic [31:0] dut_addr;
    ea  = m_axaddr(a, s);
    nb  = m_beats(s);
    pay = 16'($urandom);
    @(negedge clk);
    bus.mem_fwd_v_i        = 1'b1;
    bus.mem_fwd_last_i     = 1'b1;
    bus.mem_fwd_msg_type_i = t;
    bus.mem_fwd_addr_i     = a;
    bus.mem_fwd_size_i     = s;
    bus.mem_fwd_payload_i  = pay;
    bus.mem_fwd_data_i     = {$urandom, $urandom};
    #1;
    check_eq("ar_early", bus.m_axi_arvalid_o, 0);
    check_eq("rd_idle_no_consume", bus.mem_fwd_ready_and_o, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.m_axi_arvalid_o && k < 10);
    check_eq("ar_valid", bus.m_axi_arvalid_o, 1);
    check_eq("araddr", bus.m_axi_araddr_o, 64'(ea));
    check_eq("arlen", bus.m_axi_arlen_o, 64'(nb - 1));
    check_eq("arsize", bus.m_axi_arsize_o, (s > 3'd3) ? 64'd3 : 64'(s));
    check_eq("arburst", bus.m_axi_arburst_o, 1);
    dut_addr = bus.m_axi_araddr_o;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check_eq("ar_hold", bus.m_axi_arvalid_o, 1);
    check_eq("rd_fwd_wait", bus.mem_fwd_ready_and_o, 0);
    bus.m_axi_arready_i = 1'b1;
    #1;
    check_eq("rd_fwd_consume", bus.mem_fwd_ready_and_o, 1);
    @(negedge clk);
    bus.m_axi_arready_i = 1'b0;
    bus.mem_fwd_v_i     = 1'b0;
    bus.mem_fwd_last_i  = 1'b0;
    check_eq("ar_drop", bus.m_axi_arvalid_o, 0);
    for (int i = 0; i < nb; i++) begin
      bus.m_axi_rvalid_i = 1'b1;
      bus.m_axi_rdata_i  = mem_rd((dut_addr >> 3) + 32'(i));
      bus.m_axi_rlast_i  = (i == nb - 1);
      bus.m_axi_rresp_i  = (i == err_beat) ? 2'b10 : 2'b00;
      if (i == abort_at) begin
        #1;
        check_eq("pre_rst_rev_v", bus.mem_rev_v_o, 1);
        rst = 1'b1;
        #1;
        check_all_idle("async_rst");
        clear_inputs();
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      k = 0;
      do begin
        bus.mem_rev_ready_and_i = (k >= 4) || ($urandom_range(0, 2) != 0);
        #1;
        check_eq("rev_v", bus.mem_rev_v_o, 1);
        check_eq("rev_data", bus.mem_rev_data_o, mem_rd((ea >> 3) + 32'(i)));
        check_eq("rev_last", bus.mem_rev_last_o, (i == nb - 1));
        check_eq("rready", bus.m_axi_rready_o, bus.mem_rev_ready_and_i);
        check_hdr(t, a, s, pay);
        hs = bus.mem_rev_ready_and_i;
        @(negedge clk);
        k++;
      end while (!hs);
      if (i == err_beat) exp_err = 1'b1;
    end
    bus.m_axi_rvalid_i      = 1'b0;
    bus.m_axi_rlast_i       = 1'b0;
    bus.m_axi_rresp_i       = 2'b00;
    bus.mem_rev_ready_and_i = 1'b0;
    #1;
    check_eq("rd_done_idle", bus.mem_rev_v_o, 0);
    check_eq("rd_error", error, exp_err);
  endtask

  task automatic do_write(input logic [3:0] t, input logic [33:0] a, input logic [2:0] s,
                          input logic berr);
    int unsigned ea;
    int          nb;
    int          k;
    logic        hs;
    logic [15:0] pay;
    logic [7:0]  es;
    logic [63:0] wd [8];
    logic [63:0] w;
    ea  = m_axaddr(a, s);
    nb  = m_beats(s);
    es  = m_strb(a, s);
    pay = 16'($urandom);
    for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_fwd_v_i        = 1'b1;
    bus.mem_fwd_last_i     = (nb == 1);
    bus.mem_fwd_msg_type_i = t;
    bus.mem_fwd_addr_i     = a;
    bus.mem_fwd_size_i     = s;
    bus.mem_fwd_payload_i  = pay;
    bus.mem_fwd_data_i     = wd[0];
    #1;
    check_eq("aw_early", bus.m_axi_awvalid_o, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.m_axi_awvalid_o && k < 10);
    check_eq("aw_valid", bus.m_axi_awvalid_o, 1);
    check_eq("awaddr", bus.m_axi_awaddr_o, 64'(ea));
    check_eq("awlen", bus.m_axi_awlen_o, 64'(nb - 1));
    check_eq("awsize", bus.m_axi_awsize_o, (s > 3'd3) ? 64'd3 : 64'(s));
    check_eq("awburst", bus.m_axi_awburst_o, 1);
    check_eq("wr_addr_no_consume", bus.mem_fwd_ready_and_o, 0);
    check_eq("wr_addr_no_wvalid", bus.m_axi_wvalid_o, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.m_axi_awready_i = 1'b1;
    @(negedge clk);
    bus.m_axi_awready_i = 1'b0;
    check_eq("aw_drop", bus.m_axi_awvalid_o, 0);
    for (int i = 0; i < nb; i++) begin
      bus.mem_fwd_data_i = wd[i];
      bus.mem_fwd_last_i = (i == nb - 1);
      k = 0;
      do begin
        bus.m_axi_wready_i = (k >= 4) || ($urandom_range(0, 2) != 0);
        #1;
        check_eq("wvalid", bus.m_axi_wvalid_o, 1);
        check_eq("wdata", bus.m_axi_wdata_o, wd[i]);
        check_eq("wstrb", bus.m_axi_wstrb_o, es);
        check_eq("wlast", bus.m_axi_wlast_o, (i == nb - 1));
        check_eq("w_fwd_ready", bus.mem_fwd_ready_and_o, bus.m_axi_wready_i);
        hs = bus.m_axi_wready_i;
        if (hs) begin
          w = mem_rd((ea >> 3) + 32'(i));
          for (int b = 0; b < 8; b++) if (es[b]) w[b*8 +: 8] = wd[i][b*8 +: 8];
          mem[(ea >> 3) + 32'(i)] = w;
        end
        @(negedge clk);
        k++;
      end while (!hs);
    end
    bus.mem_fwd_v_i    = 1'b0;
    bus.mem_fwd_last_i = 1'b0;
    bus.m_axi_wready_i = 1'b0;
    #1;
    check_eq("bready", bus.m_axi_bready_o, 1);
    check_eq("wr_no_early_ack", bus.mem_rev_v_o, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.m_axi_bvalid_i = 1'b1;
    bus.m_axi_bresp_i  = berr ? 2'b10 : 2'b00;
    @(negedge clk);
    bus.m_axi_bvalid_i = 1'b0;
    bus.m_axi_bresp_i  = 2'b00;
    if (berr) exp_err = 1'b1;
    #1;
    check_eq("ack_bready_drop", bus.m_axi_bready_o, 0);
    k = 0;
    do begin
      bus.mem_rev_ready_and_i = (k >= 3) || ($urandom_range(0, 1) != 0);
      #1;
      check_eq("ack_v", bus.mem_rev_v_o, 1);
      check_eq("ack_last", bus.mem_rev_last_o, 1);
      check_eq("ack_data", bus.mem_rev_data_o, 0);
      check_hdr(t, a, s, pay);
      hs = bus.mem_rev_ready_and_i;
      @(negedge clk);
      k++;
    end while (!hs);
    bus.mem_rev_ready_and_i = 1'b0;
    #1;
    check_eq("wr_done_idle", bus.mem_rev_v_o, 0);
    check_eq("wr_error", error, exp_err);
  endtask

  task automatic do_drain(input logic [3:0] t, input int nb);
    logic [15:0] pay;
    pay = 16'($urandom);
    @(negedge clk);
    bus.mem_fwd_v_i        = 1'b1;
    bus.mem_fwd_last_i     = (nb == 1);
    bus.mem_fwd_msg_type_i = t;
    bus.mem_fwd_addr_i     = BASE + 34'h40;
    bus.mem_fwd_size_i     = 3'd3;
    bus.mem_fwd_payload_i  = pay;
    bus.mem_fwd_data_i     = {$urandom, $urandom};
    #1;
    check_eq("drain_idle_no_consume", bus.mem_fwd_ready_and_o, 0);
    exp_err = 1'b1;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.mem_fwd_last_i = (i == nb - 1);
      #1;
      check_eq("drain_ready", bus.mem_fwd_ready_and_o, 1);
      check_eq("drain_no_ar", bus.m_axi_arvalid_o, 0);
      check_eq("drain_no_aw", bus.m_axi_awvalid_o, 0);
      check_eq("drain_error", error, 1);
    end
    @(negedge clk);
    bus.mem_fwd_v_i    = 1'b0;
    bus.mem_fwd_last_i = 1'b0;
    #1;
    check_eq("drain_ack_v", bus.mem_rev_v_o, 1);
    check_eq("drain_ack_last", bus.mem_rev_last_o, 1);
    check_eq("drain_ack_data", bus.mem_rev_data_o, 0);
    check_eq("drain_ack_type", bus.mem_rev_msg_type_o, t);
    bus.mem_rev_ready_and_i = 1'b1;
    @(negedge clk);
    bus.mem_rev_ready_and_i = 1'b0;
    #1;
    check_eq("drain_done_idle", bus.mem_rev_v_o, 0);
  endtask

  task automatic random_traffic(input int n);
    int          s;
    int unsigned off;
    logic [3:0]  t;
    for (int j = 0; j < n; j++) begin
      s   = $urandom_range(0, 6);
      off = $urandom_range(0, 32'hFFFF);
      t   = 4'($urandom_range(0, 3));
      if (s < 3) off = (off / (32'd1 << s)) * (32'd1 << s);
      if (t[0]) do_write(t, BASE + 34'(off), 3'(s), 1'b0);
      else      do_read(t, BASE + 34'(off), 3'(s), -1, -1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err  = 1'b0;
    rst      = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_all_idle("reset");
    rst = 1'b0;

    do_read(4'd0, 34'h0_8000_1040, 3'd6, -1, -1);
    do_write(4'd1, 34'h0_8000_2000, 3'd6, 1'b0);
    do_write(4'd3, 34'h0_8000_0006, 3'd1, 1'b0);
    do_read(4'd0, 34'h0_8000_2000, 3'd6, -1, -1);
    do_read(4'd2, 34'h0_8000_0006, 3'd1, -1, -1);
    do_write(4'd3, 34'h0_8000_0011, 3'd0, 1'b0);
    do_read(4'd2, 34'h0_8000_0010, 3'd3, -1, -1);
    random_traffic(24);

    do_read(4'd0, 34'h0_8000_3018, 3'd6, 3, -1);
    do_read(4'd2, 34'h0_8000_3000, 3'd3, -1, -1);
    do_drain(4'd5, 1);
    do_drain(4'hC, 3);
    do_write(4'd1, 34'h0_8000_4000, 3'd5, 1'b1);

    do_read(4'd0, 34'h0_8000_1040, 3'd6, -1, 3);
    do_read(4'd0, 34'h0_8000_1040, 3'd6, -1, -1);
    random_traffic(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_zynq_mem_axi_bridge.md
# bp_zynq_mem_axi_bridge

Converts BlackParrot BedRock memory-forward messages (34-bit physical address, 64-bit fill width) into AXI4 read/write bursts toward the Zynq PS HP DRAM port, and returns BedRock memory-reverse responses. It sits directly downstream of the unicore ZynqParrot processor's memory port and upstream of the PS AXI interconnect. It handles one transaction at a time.

## Interface
- paddr_width_p, 34, BedRock physical address width
- data_width_p, 64, BedRock beat width and AXI data width
- payload_width_p, 16, opaque BedRock payload; returned unchanged
- axi_addr_width_p, 32, AXI address width
- dram_base_p, 34'h0_8000_0000, subtracted from the BedRock address to form the AXI address
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- mem_fwd_v_i / mem_fwd_ready_and_o  in/out  1  forward beat handshake
- mem_fwd_last_i  in  1  final beat of the message
- mem_fwd_msg_type_i  in  4  0=rd, 1=wr, 2=uc_rd, 3=uc_wr, others unsupported
- mem_fwd_addr_i  in  paddr_width_p  byte address
- mem_fwd_size_i  in  3  log2(bytes), 0..6
- mem_fwd_payload_i  in  payload_width_p  opaque
- mem_fwd_data_i  in  data_width_p  write data beat
- mem_rev_v_o / mem_rev_ready_and_i  out/in  1  reverse beat handshake
- mem_rev_last_o  out  1  final response beat
- mem_rev_msg_type_o, mem_rev_addr_o, mem_rev_size_o, mem_rev_payload_o  out  4/paddr/3/payload  latched request header
- mem_rev_data_o  out  data_width_p  read data; 0 for write acks
- m_axi_aw{addr,len,size,burst,valid}_o, m_axi_awready_i  AXI4 write address
- m_axi_w{data,strb,last,valid}_o, m_axi_wready_i  AXI4 write data
- m_axi_b{resp,valid}_i, m_axi_bready_o  AXI4 write response
- m_axi_ar{addr,len,size,burst,valid}_o, m_axi_arready_i  AXI4 read address
- m_axi_r{data,resp,last,valid}_i, m_axi_rready_o  AXI4 read data
- error_o  out  1  sticky: nonzero BRESP/RRESP or unsupported msg_type

## Operation
- The header fields are stable on every beat of a message. The bridge latches them in IDLE on the first cycle that mem_fwd_v_i=1 and does not consume a beat in IDLE.
- Derived values: bytes=2^size; beats=max(1,bytes/8); axlen=beats-1; axsize=min(size,3); burst=INCR.
- axaddr=(addr-dram_base_p)[axi_addr_width_p-1:0]. When size>=3 the low size bits are forced to 0. When size<3 the address is kept exact.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, ACK, DRAIN.
- IDLE -> RD_ADDR for type 0/2, WR_ADDR for type 1/3, DRAIN otherwise (error_o set).
- RD_ADDR: arvalid=1. On the AR handshake, mem_fwd_ready_and_o=1 in the same cycle to consume the single read beat; go to RD_DATA.
- RD_DATA: R passes through combinationally. mem_rev_v_o=rvalid, rready=mem_rev_ready_and_i, data=rdata, last=rlast. On the handshake with rlast=1, go to IDLE.
- WR_ADDR: awvalid=1; on the handshake go to WR_DATA.
- WR_DATA: W passes through combinationally. wvalid=mem_fwd_v_i, mem_fwd_ready_and_o=wready, wlast=mem_fwd_last_i.
  - wstrb=8'hFF when size>=3, else (2^bytes-1)<<addr[2:0].
  - On the handshake of the last beat, go to WR_RESP.
- WR_RESP: bready=1; on B, go to ACK.
- ACK: one beat with mem_rev_v_o=1, last=1, data=0. On the handshake, go to IDLE.
- DRAIN: mem_fwd_ready_and_o=1 until the last beat is consumed, then ACK.
- A nonzero rresp or bresp on any handshake sets error_o. Only reset clears it.

## Timing
- Reset values: all valid and ready outputs 0, error_o=0, state IDLE, latched header 0.
- Asynchronous reset mid-transaction returns to IDLE immediately and abandons the outstanding AXI transaction. The system reset covers both sides.
- AR/AW valid is registered: earliest assertion is 1 cycle after mem_fwd_v_i rises in IDLE.
- The R->mem_rev and mem_fwd->W paths have zero added latency and are combinational.
- The write ack arrives 1 cycle after the B handshake.
- A new request is accepted on the cycle after the final rev handshake.
- Valid is held until ready; no output valid deasserts without a handshake.

## Test plan
- 64B cached read, addr 0x0_8000_1040, size 6 -> araddr 0x1040, arlen 7, arsize 3. Eight rdata beats are forwarded in order, with last on beat 8 and the header echoed.
- 64B write, addr 0x0_8000_2000, 8 beats with random wready stalls -> awaddr 0x2000, awlen 7, all wstrb 0xFF, wlast on beat 8. One zero-data ack with last=1 follows the B handshake.
- 2B uc_wr, addr 0x0_8000_0006 -> awaddr 0x6, awlen 0, awsize 1, wstrb 0xC0, single ack.
- Read with bresp/rresp=2'b10 on one beat -> error_o rises and stays high. The response still completes normally.
- msg_type 5 with 1 beat -> no AXI activity; the beat is drained; ack returned; error_o=1.
- Assert reset during RD_DATA after 3 of 8 beats -> all valid outputs 0 immediately; the next read after reset completes correctly.
